aes_axil_reg_slave: RTL and testbench

//  AXI4-Lite slave register file that terminates the host/VIP master side of the AES_PROCESS IP.

---
 rtl/aes_axil_reg_slave.sv | 182 ++++++++++++++++++
 tb/tb_aes_axil_reg_slave.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axil_reg_slave.sv
// AXI4-Lite register slave for the AES core: RW key/pt words, CTRL start/status, RO ciphertext.
// Write commits the cycle after AW and W are both held; reads respond one cycle after AR; each channel holds until its READY.
module aes_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_RW_REGS        = 8,
  parameter int NUM_RO_REGS        = 4
) (
  input  logic                                        S_AXI_ACLK,
  input  logic                                        S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
  input  logic                                        S_AXI_AWVALID,
  output logic                                        S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
  input  logic                                        S_AXI_WVALID,
  output logic                                        S_AXI_WREADY,
  output logic [1:0]                                  S_AXI_BRESP,
  output logic                                        S_AXI_BVALID,
  input  logic                                        S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
  input  logic                                        S_AXI_ARVALID,
  output logic                                        S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
  output logic [1:0]                                  S_AXI_RRESP,
  output logic                                        S_AXI_RVALID,
  input  logic                                        S_AXI_RREADY,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]   rw_regs_o,
  output logic                                        start_o,
  input  logic                                        core_done_i,
  input  logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]   ro_regs_i
);

  localparam int         DW          = C_S_AXI_DATA_WIDTH;
  localparam int         SW          = DW / 8;
  localparam int         RW_IW       = $clog2(NUM_RW_REGS);
  localparam int         RO_IW       = $clog2(NUM_RO_REGS);
  localparam logic [3:0] CTRL_IDX    = 4'(NUM_RW_REGS);
  localparam logic [3:0] RO_BASE     = 4'(NUM_RW_REGS + 1);
  localparam logic [3:0] RO_END      = 4'(NUM_RW_REGS + 1 + NUM_RO_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                           r_aw_vld;
  logic [3:0]                     r_aw_idx;
  logic                           r_w_vld;
  logic [DW-1:0]                  r_wdata;
  logic [SW-1:0]                  r_wstrb;
  logic                           r_bvalid;
  logic [1:0]                     r_bresp;
  logic                           r_rvalid;
  logic [DW-1:0]                  r_rdata;
  logic [1:0]                     r_rresp;
  logic [NUM_RW_REGS-1:0][DW-1:0] r_rw;
  logic                           r_start;
  logic                           r_busy;
  logic                           r_done;

  logic                           w_aw_hs;
  logic                           w_w_hs;
  logic                           w_ar_hs;
  logic                           w_commit;
  logic                           w_start;
  logic [3:0]                     w_wr_idx;
  logic [DW-1:0]                  w_wdata;
  logic [SW-1:0]                  w_wstrb;
  logic [3:0]                     w_rd_idx;
  logic [DW-1:0]                  w_rd_data;
  logic [1:0]                     w_rd_resp;
  logic [NUM_RO_REGS-1:0][DW-1:0] w_ro;
  logic [RO_IW-1:0]               w_ro_sel;
  logic                           w_unused_addr_bits;

  assign S_AXI_AWREADY = !S_AXI_ARESET && !r_aw_vld && !r_bvalid;
  assign S_AXI_WREADY  = !S_AXI_ARESET && !r_w_vld && !r_bvalid;
  assign S_AXI_ARREADY = !S_AXI_ARESET && !r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign rw_regs_o     = r_rw;
  assign start_o       = r_start;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit on the edge where the second of AW/W lands, so a joint AW+W sees BVALID one cycle later.
  assign w_wr_idx = r_aw_vld ? r_aw_idx : S_AXI_AWADDR[5:2];
  assign w_wdata  = r_w_vld ? r_wdata : S_AXI_WDATA;
  assign w_wstrb  = r_w_vld ? r_wstrb : S_AXI_WSTRB;
  assign w_commit = (r_aw_vld || w_aw_hs) && (r_w_vld || w_w_hs) && !r_bvalid;
  assign w_start  = w_commit && (w_wr_idx == CTRL_IDX) && w_wstrb[0] && w_wdata[0];

  assign w_rd_idx           = S_AXI_ARADDR[5:2];
  assign w_ro               = ro_regs_i;
  assign w_ro_sel           = RO_IW'(w_rd_idx - RO_BASE);
  assign w_unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (w_rd_idx < CTRL_IDX) begin
      w_rd_data = r_rw[w_rd_idx[RW_IW-1:0]];
    end else if (w_rd_idx == CTRL_IDX) begin
      w_rd_data = {{(DW-2){1'b0}}, r_done, r_busy};
    end else if (w_rd_idx < RO_END) begin
      w_rd_data = w_ro[w_ro_sel];
    end else begin
      w_rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_aw_vld <= 1'b0;
      r_aw_idx <= '0;
      r_w_vld  <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_rw     <= '0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_start;
      if (w_aw_hs) begin
        r_aw_vld <= 1'b1;
        r_aw_idx <= S_AXI_AWADDR[5:2];
      end
      if (w_w_hs) begin
        r_w_vld <= 1'b1;
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wr_idx <= CTRL_IDX) ? RESP_OKAY : RESP_SLVERR;
        if (w_wr_idx < CTRL_IDX) begin
          for (int b = 0; b < SW; b++) begin
            if (w_wstrb[b]) r_rw[w_wr_idx[RW_IW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
          end
        end
      end
      if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
        r_aw_vld <= 1'b0;
        r_w_vld  <= 1'b0;
      end
    end
  end

  // A start landing together with core_done_i wins: the new run is busy and not yet done.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (core_done_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_axil_reg_slave.sv
// Bench for aes_axil_reg_slave: vector table plus hand-driven timing sequences.
// Expected B/R responses are queued when a request is driven and compared when the handshake is seen.
module tb_aes_axil_reg_slave;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [5:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [255:0] rw_regs;
  logic         start_o;
  logic         core_done;
  logic [127:0] ro_regs;

  always #5 clk = ~clk;

  aes_axil_reg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .rw_regs_o(rw_regs), .start_o(start_o), .core_done_i(core_done), .ro_regs_i(ro_regs)
  );

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         start_cnt = 0;
  int         bad_start = 0;
  logic [1:0] m_be;
  rexp_t      m_re;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(bit w, logic [5:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] ed, logic [1:0] er);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
    return v;
  endfunction

  // Scoreboard side: a handshake completes on the posedge following a negedge with VALID&READY.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected: got bresp 0x%0h with nothing expected", bresp);
        end else begin
          m_be = bq.pop_front();
          check("bresp", {254'd0, bresp}, {254'd0, m_be});
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_checks++;
          $display("FAIL r_unexpected: got rdata 0x%0h with nothing expected", rdata);
        end else begin
          m_re = rq.pop_front();
          check("rdata", {224'd0, rdata}, {224'd0, m_re.data});
          check("rresp", {254'd0, rresp}, {254'd0, m_re.resp});
        end
      end
      if (start_o) begin
        start_cnt++;
        if (!bvalid) bad_start++;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d b / %0d r pending expected 0", bq.size(), rq.size());
      bq.delete();
      rq.delete();
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    bit aw_ok = 0;
    bit w_ok = 0;
    bit hs_aw;
    bit hs_w;
    int n = 0;
    bq.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < 50) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) begin awvalid = 1'b0; aw_ok = 1; end
      if (hs_w)  begin wvalid = 1'b0; w_ok = 1; end
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL write_accept_timeout: got aw=%0d w=%0d expected both accepted", aw_ok, w_ok);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    drain();
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit hs;
    int n = 0;
    rq.push_back('{data: ed, resp: er});
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 50) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      n_checks++;
      $display("FAIL read_accept_timeout: got arvalid stuck expected accept");
      arvalid = 1'b0;
    end
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   n;

    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1; core_done = 1'b0;
    ro_regs = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00C0FFEE};

    vecs.push_back(mk(1, 6'h00, 32'h1, 4'hF, 32'h0, OK));
    vecs.push_back(mk(1, 6'h04, 32'h2, 4'hF, 32'h0, OK));
    vecs.push_back(mk(1, 6'h08, 32'h3, 4'hF, 32'h0, OK));
    vecs.push_back(mk(1, 6'h0C, 32'h4, 4'hF, 32'h0, OK));
    vecs.push_back(mk(0, 6'h00, 32'h0, 4'h0, 32'h1, OK));
    vecs.push_back(mk(0, 6'h04, 32'h0, 4'h0, 32'h2, OK));
    vecs.push_back(mk(0, 6'h08, 32'h0, 4'h0, 32'h3, OK));
    vecs.push_back(mk(0, 6'h0C, 32'h0, 4'h0, 32'h4, OK));
    vecs.push_back(mk(1, 6'h14, 32'hAABBCCDD, 4'hF, 32'h0, OK));
    vecs.push_back(mk(1, 6'h14, 32'h11223344, 4'h5, 32'h0, OK));
    vecs.push_back(mk(0, 6'h14, 32'h0, 4'h0, 32'hAA22CC44, OK));
    vecs.push_back(mk(1, 6'h18, 32'h12345678, 4'h0, 32'h0, OK));
    vecs.push_back(mk(0, 6'h18, 32'h0, 4'h0, 32'h0, OK));
    vecs.push_back(mk(1, 6'h24, 32'hFFFFFFFF, 4'hF, 32'h0, ERR));
    vecs.push_back(mk(0, 6'h24, 32'h0, 4'h0, 32'h00C0FFEE, OK));
    vecs.push_back(mk(0, 6'h30, 32'h0, 4'h0, 32'h33333333, OK));
    vecs.push_back(mk(0, 6'h38, 32'h0, 4'h0, 32'h0, ERR));
    vecs.push_back(mk(1, 6'h3C, 32'h5, 4'hF, 32'h0, ERR));
    vecs.push_back(mk(0, 6'h1C, 32'h0, 4'h0, 32'h0, OK));

    @(posedge clk);
    @(negedge clk);
    check("rst_awready", {255'd0, awready}, 256'd0);
    check("rst_wready", {255'd0, wready}, 256'd0);
    check("rst_arready", {255'd0, arready}, 256'd0);
    check("rst_bvalid", {255'd0, bvalid}, 256'd0);
    check("rst_rvalid", {255'd0, rvalid}, 256'd0);
    check("rst_start", {255'd0, start_o}, 256'd0);
    check("rst_rdata", {224'd0, rdata}, 256'd0);
    check("rst_regs", rw_regs, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", {255'd0, awready}, 256'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end
    check("regs_word0", {224'd0, rw_regs[31:0]}, 256'h1);
    check("regs_word5", {224'd0, rw_regs[191:160]}, 256'hAA22CC44);

    // W three cycles ahead of AW
    bq.push_back(OK);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("w_first_wready", {255'd0, wready}, 256'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("w_held_wready", {255'd0, wready}, 256'd0);
      check("w_held_bvalid", {255'd0, bvalid}, 256'd0);
      @(posedge clk); #1;
    end
    awaddr = 6'h10; awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_awready", {255'd0, awready}, 256'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("aw_late_bvalid", {255'd0, bvalid}, 256'd1);
    @(posedge clk); #1;
    drain();
    do_read(6'h10, 32'hDEADBEEF, OK);

    // CTRL start / done
    n = start_cnt;
    do_write(6'h20, 32'h1, 4'hF, OK);
    check("start_pulses", 256'(start_cnt - n), 256'd1);
    check("start_low_after", {255'd0, start_o}, 256'd0);
    do_read(6'h20, 32'h1, OK);
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    do_read(6'h20, 32'h2, OK);
    ro_regs[31:0] = 32'hCAFEF00D;
    do_read(6'h24, 32'hCAFEF00D, OK);
    n = start_cnt;
    do_write(6'h20, 32'h0, 4'hF, OK);
    check("ctrl_zero_no_start", 256'(start_cnt - n), 256'd0);
    do_read(6'h20, 32'h2, OK);

    // start and core_done on the same commit edge
    bq.push_back(OK);
    awaddr = 6'h20; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; core_done = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
    drain();
    do_read(6'h20, 32'h1, OK);
    check("start_coincides_bvalid", 256'(bad_start), 256'd0);

    // read and write of the same word in one cycle: read sees the old value
    bq.push_back(OK);
    rq.push_back('{data: 32'h0, resp: OK});
    awaddr = 6'h1C; wdata = 32'h77; wstrb = 4'hF; araddr = 6'h1C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("same_cyc_ready", {253'd0, awready, wready, arready}, 256'h7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    drain();
    do_read(6'h1C, 32'h77, OK);

    // responses held off, then reset in the middle of the hold
    bready = 1'b0; rready = 1'b0;
    awaddr = 6'h00; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("hold_bvalid", {255'd0, bvalid}, 256'd1);
    check("hold_rvalid", {255'd0, rvalid}, 256'd1);
    check("hold_rdata", {224'd0, rdata}, 256'h2);
    check("hold_reg0", {224'd0, rw_regs[31:0]}, 256'h55);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_arready", {255'd0, arready}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_bvalid", {255'd0, bvalid}, 256'd0);
    check("post_rst_rvalid", {255'd0, rvalid}, 256'd0);
    check("post_rst_regs", rw_regs, 256'd0);
    @(posedge clk); #1;
    bready = 1'b1; rready = 1'b1;
    do_write(6'h08, 32'hA5A5A5A5, 4'hF, OK);
    do_read(6'h08, 32'hA5A5A5A5, OK);
    do_read(6'h00, 32'h0, OK);
    do_read(6'h20, 32'h0, OK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
